// File: rtl/gpu_pkg.sv
// Shared VRAM access controller constants: address width, register offsets,
// STATUS/CTRL bit positions and the arbitration state type.
package gpu_pkg;
    localparam int VRAM_ADDR_W = 13;

    localparam logic [3:0] REG_ADDR_LO = 4'h0;
    localparam logic [3:0] REG_ADDR_HI = 4'h1;
    localparam logic [3:0] REG_DATA    = 4'h2;
    localparam logic [3:0] REG_INCR    = 4'h3;
    localparam logic [3:0] REG_CTRL    = 4'h4;
    localparam logic [3:0] REG_STATUS  = 4'h5;

    localparam int STAT_EMPTY    = 0;
    localparam int STAT_FULL     = 1;
    localparam int STAT_IRQ_PEND = 2;
    localparam int STAT_OVF      = 3;

    localparam int CTRL_IRQ_EN  = 0;
    localparam int CTRL_IRQ_CLR = 1;
    localparam int CTRL_OVF_CLR = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PIX,
        ST_CPU
    } arb_state_e;
endpackage

// File: rtl/vram_wr_fifo.sv
// CPU write queue: DEPTH entries of W bits, head visible combinationally.
// DEPTH must be a power of two so the pointers wrap naturally.
module vram_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 21
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt;
    logic          w_do_push, w_do_pop;

    assign full      = (r_cnt == (AW+1)'(DEPTH));
    assign empty     = (r_cnt == '0);
    assign w_do_pop  = pop & ~empty;
    // A pop frees the slot in the same cycle, so a full queue still accepts.
    assign w_do_push = push & (~full | w_do_pop);
    assign dout      = r_mem[r_rp];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) r_wp <= r_wp + 1'b1;
            if (w_do_pop)  r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wp] <= din;
    end
endmodule

// File: rtl/vram_access_ctrl.sv
// VRAM arbiter between the pixel fetcher and a queued CPU register port.
// Define VRAM_AUTOINC_EN to enable the INCR register and pointer auto-increment.
module vram_access_ctrl
    import gpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = VRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_cs,
    input  logic              cpu_rw,
    input  logic [3:0]        cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    input  logic              pix_req,
    input  logic [ADDR_W-1:0] pix_addr,
    output logic              pix_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic              vblank,
    output logic              irq
);
    logic [ADDR_W-1:0] r_ptr;
    logic              r_irq_en, r_irq_pend, r_ovf, r_vblank_q;
    logic [7:0]        r_rdata;

    arb_state_e        w_state;
    logic              w_wr, w_push, w_accept, w_pop, w_full, w_empty;
    logic              w_ctrl_wr, w_vb_rise;
    logic [ADDR_W+7:0] w_head;
    logic [ADDR_W-1:0] w_ptr_adv;
    logic [7:0]        w_status;

    assign w_wr      = cpu_cs & ~cpu_rw;
    assign w_push    = w_wr & (cpu_addr == REG_DATA);
    assign w_ctrl_wr = w_wr & (cpu_addr == REG_CTRL);
    assign w_accept  = w_push & (~w_full | w_pop);
    assign w_vb_rise = vblank & ~r_vblank_q;
    assign w_pop     = mem_we;
    assign irq       = r_irq_pend & r_irq_en;
    assign cpu_rdata = r_rdata;

    vram_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ADDR_W + 8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_accept),
        .din   ({r_ptr, cpu_wdata}),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // Zero-latency arbitration: the state is decoded fresh every cycle.
    always_comb begin
        w_state   = ST_IDLE;
        pix_gnt   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pix_addr;
        mem_wdata = '0;
        if (rst) begin
            if (pix_req)       w_state = ST_PIX;
            else if (!w_empty) w_state = ST_CPU;
        end
        case (w_state)
            ST_PIX: pix_gnt = 1'b1;
            ST_CPU: begin
                mem_we    = 1'b1;
                mem_addr  = w_head[ADDR_W+7:8];
                mem_wdata = w_head[7:0];
            end
            default: ;
        endcase
    end

`ifdef VRAM_AUTOINC_EN
    logic [7:0] r_incr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                r_incr <= 8'h01;
        else if (w_wr && cpu_addr == REG_INCR)   r_incr <= cpu_wdata;
    end

    assign w_ptr_adv = r_ptr + {{(ADDR_W-8){1'b0}}, r_incr};
`else
    assign w_ptr_adv = r_ptr;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                   r_ptr <= '0;
        else if (w_wr && cpu_addr == REG_ADDR_LO)   r_ptr[7:0] <= cpu_wdata;
        else if (w_wr && cpu_addr == REG_ADDR_HI)   r_ptr[ADDR_W-1:8] <= cpu_wdata[ADDR_W-9:0];
        else if (w_accept)                          r_ptr <= w_ptr_adv;
    end

    always_comb begin
        w_status                = '0;
        w_status[STAT_EMPTY]    = w_empty;
        w_status[STAT_FULL]     = w_full;
        w_status[STAT_IRQ_PEND] = r_irq_pend;
        w_status[STAT_OVF]      = r_ovf;
    end

    // A vblank rise outranks a simultaneous software clear of irq_pend.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vblank_q <= 1'b0;
            r_irq_en   <= 1'b0;
            r_irq_pend <= 1'b0;
            r_ovf      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_vblank_q <= vblank;
            if (w_ctrl_wr) r_irq_en <= cpu_wdata[CTRL_IRQ_EN];
            if (w_vb_rise)                                  r_irq_pend <= 1'b1;
            else if (w_ctrl_wr && cpu_wdata[CTRL_IRQ_CLR])  r_irq_pend <= 1'b0;
            if (w_push && !w_accept)                        r_ovf <= 1'b1;
            else if (w_ctrl_wr && cpu_wdata[CTRL_OVF_CLR])  r_ovf <= 1'b0;
            if (cpu_cs && cpu_rw)
                r_rdata <= (cpu_addr == REG_STATUS) ? w_status : 8'h00;
        end
    end
endmodule

// File: doc/vram_access_ctrl.md
VRAM_ACCESS_CTRL -- requirements
Module: vram_access_ctrl

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of entries in the CPU write queue (power of two, at least 2).
REQ-002 The block SHALL have parameter ADDR_W, default 13, meaning the VRAM address width in bits.
REQ-003 clk  input  1  system clock (CLK100MHz domain); all logic is on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 cpu_cs  input  1  one-cycle access strobe, already synchronous to clk.
REQ-006 cpu_rw  input  1  access direction: 1 = read, 0 = write.
REQ-007 cpu_addr  input  4  register offset.
REQ-008 cpu_wdata  input  8  register write data.
REQ-009 cpu_rdata  output  8  register read data.
REQ-010 pix_req  input  1  pixel generator requests a VRAM read this cycle.
REQ-011 pix_addr  input  ADDR_W  pixel read address.
REQ-012 pix_gnt  output  1  pixel read is granted this cycle.
REQ-013 mem_addr  output  ADDR_W  VRAM address.
REQ-014 mem_we  output  1  VRAM write enable.
REQ-015 mem_wdata  output  8  VRAM write data.
REQ-016 vblank  input  1  vertical blank level from the sync generator.
REQ-017 irq  output  1  level interrupt to the CPU.

Function
REQ-018 Register map, writes (cpu_cs=1, cpu_rw=0):
- 0x0 ADDR_LO: ptr[7:0].
- 0x1 ADDR_HI: ptr[ADDR_W-1:8] = cpu_wdata[4:0].
- 0x2 DATA: push {ptr, cpu_wdata} into the write queue.
- 0x3 INCR: 8-bit pointer increment.
- 0x4 CTRL: bit0 irq_en; bit1 writing 1 clears irq_pend; bit2 writing 1 clears ovf.
REQ-019 Register map, reads: 0x5 STATUS = {4'b0, ovf, irq_pend, full, empty}; every other offset reads 0x00.
REQ-020 cpu_rdata SHALL be registered: valid the cycle after a read strobe and held until the next read strobe.
REQ-021 Each accepted DATA write SHALL advance ptr by INCR, modulo 2^ADDR_W; 0x1FFF + 1 wraps to 0x0000.
REQ-022 Arbitration each cycle, pixel has absolute priority:
- pix_req=1: pix_gnt=1, mem_addr=pix_addr, mem_we=0.
- else if the queue is not empty: mem_we=1, mem_addr/mem_wdata = queue head, and the head is popped.
- else: mem_we=0, mem_addr=pix_addr.
REQ-023 Arbitration outputs SHALL be combinational from pix_req and queue state (zero latency); write-to-VRAM latency from the DATA strobe is at least 1 cycle.
REQ-024 A push while the queue is full and no pop occurs that cycle SHALL be dropped, set ovf (sticky), and leave ptr unchanged.
REQ-025 A push while full with a simultaneous pop SHALL be accepted.
REQ-026 A push into an empty queue SHALL NOT write VRAM in the same cycle.
REQ-027 A rising edge of vblank SHALL set irq_pend; irq = irq_pend & irq_en.
REQ-028 A clear of irq_pend coinciding with a vblank rising edge SHALL leave irq_pend set.
REQ-029 The controller SHALL be the FSM IDLE/PIX/CPU, evaluated every cycle:
- PIX when pix_req=1.
- CPU when pix_req=0 and the queue is not empty.
- otherwise IDLE.
The state is observable via pix_gnt and mem_we only.

Reset
REQ-030 While rst=0, all of the following SHALL be 0 or empty: ptr, INCR, irq_en, irq_pend, ovf, the queue, cpu_rdata, the vblank edge register, pix_gnt, mem_we, mem_wdata; mem_addr = pix_addr.
REQ-031 Reset asserted mid-operation SHALL discard queued writes with no partial VRAM write afterwards.
REQ-032 After reset release, the first vblank edge SHALL be detected only on a 0->1 transition sampled after release.

Configuration
REQ-033 With VRAM_AUTOINC_EN defined:
- ptr advances by INCR as in REQ-021.
- INCR resets to 0x01.
REQ-034 Without VRAM_AUTOINC_EN:
- ptr never advances on DATA writes.
- offset 0x3 is ignored.
- INCR logic is absent.

Structure
REQ-035 Package gpu_pkg SHALL hold VRAM_ADDR_W = 13, the register offset constants REG_ADDR_LO through REG_STATUS, and the STATUS/CTRL bit index constants.
REQ-036 The queue SHALL be the sub-module vram_wr_fifo: FIFO_DEPTH entries of ADDR_W+8 bits, with push/pop/full/empty and no read latency (head visible combinationally).

Verification
REQ-037 The bench SHALL cover the following directed scenarios:
- Write ADDR_LO=0x34, ADDR_HI=0x12, INCR=1, DATA 0xAA, 0xBB with pix_req=0 -> mem_we pulses with (0x1234, 0xAA) then (0x1235, 0xBB).
- ptr=0x1FFF, INCR=2, two DATA writes -> VRAM writes at 0x1FFF then 0x0001.
- Hold pix_req=1 for 10 cycles and push 6 DATA writes -> no mem_we during the hold; 4 accepted, STATUS=0x0A (ovf, full); after pix_req drops, 4 writes in consecutive cycles.
- irq_en=1, vblank 0->1 -> irq=1 next cycle; CTRL write 0x03 -> irq=0; vblank held high -> irq stays 0.
- Three queued writes then rst=0 for 1 cycle -> mem_we=0 afterwards; STATUS reads 0x01.
- Build without VRAM_AUTOINC_EN: two DATA writes -> both written to the same address.
